// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, PC step, default vectors and redirect source priority
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, REQ, KILL, HOLD} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_BR, SRC_JMP, SRC_EXC} redir_src_e;
  localparam int unsigned PC_STEP = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
  function automatic redir_src_e redir_src(input logic exc, input logic jmp, input logic br);
    return exc ? SRC_EXC : jmp ? SRC_JMP : br ? SRC_BR : SRC_NONE;
  endfunction
endpackage

// File: rtl/fetch_redirect_sel.sv
// fetch_redirect_sel: picks the highest-priority redirect and word-aligns its target
module fetch_redirect_sel
  import fetch_pkg::*;
#(
  parameter int AW = 32,
  parameter logic [AW-1:0] EXC_VECTOR = AW'(DEF_EXC_VECTOR)
) (
  input  logic          exc_req,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_target,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          redir,
  output logic [AW-1:0] target
);
  redir_src_e src;
  logic [AW-1:0] raw;
  always_comb begin
    src = redir_src(exc_req, jmp_req, br_taken);
    raw = src == SRC_EXC ? EXC_VECTOR : src == SRC_JMP ? jmp_target : br_target;
    redir = src != SRC_NONE;
    target = raw & ~AW'(3);
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and imem request sequencer; define FETCH_CNT_EN to add fetch_count
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(DEF_RESET_VECTOR),
  parameter logic [AW-1:0] EXC_VECTOR = AW'(DEF_EXC_VECTOR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          exc_req,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_target,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [AW-1:0] if_pc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);
  state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pend_q, pend_d, if_pc_q, if_pc_d, target, pc_inc;
  logic [31:0] if_instr_q, if_instr_d;
  logic if_valid_q, if_valid_d, redir;
  fetch_redirect_sel #(.AW(AW), .EXC_VECTOR(EXC_VECTOR)) u_sel (
    .exc_req(exc_req),
    .jmp_req(jmp_req),
    .jmp_target(jmp_target),
    .br_taken(br_taken),
    .br_target(br_target),
    .redir(redir),
    .target(target)
  );
  assign pc_inc = pc_q + AW'(PC_STEP);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d = if_pc_q;
    case (state_q)
      BOOT: begin
        state_d = REQ;
        pc_d = redir ? target : pc_q;
      end
      REQ:
        if (imem_ack) begin
          if_valid_d = !redir;
          if (redir) pc_d = target;
          else begin
            pc_d = pc_inc;
            if_instr_d = imem_rdata;
            if_pc_d = pc_q;
            state_d = stall ? HOLD : REQ;
          end
        end else if (redir) begin
          // the in-flight request must still complete at the old address
          if_valid_d = 1'b0;
          pend_d = target;
          state_d = KILL;
        end else if (!stall) if_valid_d = 1'b0;
      KILL: begin
        if_valid_d = 1'b0;
        pend_d = redir ? target : pend_q;
        if (imem_ack) begin
          pc_d = pend_d;
          state_d = REQ;
        end
      end
      HOLD:
        if (redir || !stall) begin
          if_valid_d = 1'b0;
          pc_d = redir ? target : pc_q;
          state_d = REQ;
        end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      pend_q <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q <= if_pc_d;
    end
  assign imem_req = state_q == REQ || state_q == KILL;
  assign imem_addr = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc = if_pc_q;
`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + {31'd0, if_valid_q & ~stall};
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign fetch_count = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plus randomized fetch traffic scored against a behavioural model
module tb_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, exc_req = 1'b0, jmp_req = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] jmp_target = '0, br_target = '0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif
  int checks = 0, errors = 0;
  typedef struct packed {
    logic boot, hold, doom, v;
    logic [31:0] pc, pend, opc, oi, cnt;
  } model_t;
  model_t ms, em;
  model_t exp_q[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16] ^ a[15:0]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  always #5 clk = ~clk;
  fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .exc_req(exc_req),
    .jmp_req(jmp_req),
    .jmp_target(jmp_target),
    .br_taken(br_taken),
    .br_target(br_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc)
`ifdef FETCH_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );
  // One cycle of the fetch rules: boot, holding, killed-request and live-request situations.
  function automatic model_t model_next(input model_t m, input logic a, s, e, j, input logic [31:0] jt,
                                        input logic b, input logic [31:0] bt);
    model_t n = m;
    logic red = e | j | b;
    logic [31:0] t = e ? 32'h80 : j ? (jt & ~32'd3) : (bt & ~32'd3);
    if (m.v && !s) n.cnt = m.cnt + 1;
    if (m.boot) begin
      n.boot = 1'b0;
      if (red) n.pc = t;
    end else if (m.hold) begin
      if (red || !s) begin
        n.hold = 1'b0;
        n.v = 1'b0;
        if (red) n.pc = t;
      end
    end else if (m.doom) begin
      n.v = 1'b0;
      if (red) n.pend = t;
      if (a) begin
        n.pc = n.pend;
        n.doom = 1'b0;
      end
    end else if (a) begin
      if (red) begin
        n.v = 1'b0;
        n.pc = t;
      end else begin
        n.v = 1'b1;
        n.opc = m.pc;
        n.oi = mem_word(m.pc);
        n.pc = m.pc + 32'd4;
        n.hold = s;
      end
    end else if (red) begin
      n.v = 1'b0;
      n.pend = t;
      n.doom = 1'b1;
    end else if (!s) n.v = 1'b0;
    return n;
  endfunction
  initial begin
    ms = '0;
    ms.boot = 1'b1;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        ms = '0;
        ms.boot = 1'b1;
        exp_q.delete();
      end else begin
        ms = model_next(ms, imem_ack, stall, exc_req, jmp_req, jmp_target, br_taken, br_target);
        exp_q.push_back(ms);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
      end else begin
        logic ok, er;
        em = exp_q.pop_front();
        er = !em.boot && !em.hold;
        ok = imem_req === er && (!er || imem_addr === em.pc) && if_valid === em.v &&
             (!em.v || (if_pc === em.opc && if_instr === em.oi));
`ifdef FETCH_CNT_EN
        ok = ok && fetch_count === em.cnt;
`endif
        if (!ok) begin
          errors++;
          $display("FAIL cycle t=%0t req %b want %b addr %h want %h valid %b want %b pc %h want %h instr %h want %h",
                   $time, imem_req, er, imem_addr, em.pc, if_valid, em.v, if_pc, em.opc, if_instr, em.oi);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic a, s, e, j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    imem_ack = a;
    stall = s;
    exc_req = e;
    jmp_req = j;
    jmp_target = jt;
    br_taken = b;
    br_target = bt;
  endtask
  task automatic step(input logic a, s, e, j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    @(negedge clk);
    #1;
    drive(a, s, e, j, jt, b, bt);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_valid", {31'd0, if_valid}, 32'd0);
    chk("reset_instr", if_instr, 32'd0);
    chk("reset_pc", if_pc, 32'd0);
    chk("reset_addr", imem_addr, 32'd0);
    #1 reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("seq0_pc", if_pc, 32'h0);
    chk("seq0_addr", imem_addr, 32'h4);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("seq1_pc", if_pc, 32'h4);
    chk("seq1_addr", imem_addr, 32'h8);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", if_pc, 32'h8);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("hold_instr", if_instr, mem_word(32'h8));
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'hC);
    step(0, 0, 0, 0, 0, 1, 32'h103);
    chk("kill_addr0", imem_addr, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("kill_addr1", imem_addr, 32'hC);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("kill_discard", {31'd0, if_valid}, 32'd0);
    chk("kill_target", imem_addr, 32'h100);
    step(1, 0, 1, 1, 32'h200, 1, 32'h300);
    chk("prio_exc", imem_addr, 32'h80);
    step(1, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
    chk("jmp_align", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 1, 32'h40);
    chk("kill2_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_refetch_req", {31'd0, imem_req}, 32'd1);
    chk("rst_refetch_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2) != 0, $urandom_range(3) == 0, $urandom_range(39) == 0, $urandom_range(24) == 0,
           $urandom, $urandom_range(14) == 0, $urandom);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer. Owns the program counter and drives the instruction-memory request handshake.
- Selects the next PC from the sequential, branch, jump and exception sources by fixed priority.
- Holds fetched instructions under decode stall.
- Sits between the imem port and the decode stage; it is the sole writer of the PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception redirect.
- AW, 32, PC/address width.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept an instruction this cycle
- exc_req  in  1  exception redirect to EXC_VECTOR
- jmp_req  in  1  jump redirect
- jmp_target  in  AW  jump target
- br_taken  in  1  taken-branch redirect
- br_target  in  AW  branch target
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc valid for decode
- if_instr  out  32  delivered instruction
- if_pc  out  AW  PC of if_instr

Behaviour:
- Reset (async, any state, mid-request included):
  - pc=RESET_VECTOR, pend=0, state=BOOT.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0.
  - An outstanding request is abandoned; imem must tolerate imem_req dropping.
- Redirect:
  - redir = exc_req|jmp_req|br_taken.
  - Target priority: exc_req (EXC_VECTOR) > jmp_req (jmp_target) > br_taken (br_target).
  - Target bits [1:0] are forced to 00.
- PC arithmetic: pc+4 modulo 2^AW; 32'hFFFF_FFFC wraps to 0.
- States:
  - BOOT: imem_req=0. Next cycle goes to REQ. A redirect in BOOT loads the target into pc.
  - REQ: imem_req=1, imem_addr=pc. Same-cycle ack is legal.
    - ack & !redir & !stall: if_valid=1 next cycle with if_instr=imem_rdata, if_pc=pc; pc<=pc+4; stay REQ. Back-to-back fetch gives 1 instruction/cycle.
    - ack & !redir & stall: capture rdata/pc into the hold register; pc<=pc+4; go HOLD.
    - ack & redir: discard data (if_valid=0); pc<=target; stay REQ.
    - !ack & redir: pend<=target; go KILL. imem_addr stays unchanged.
    - !ack & !redir: no change.
  - KILL: imem_req=1, imem_addr=old pc, if_valid=0.
    - A new redirect overwrites pend; latest cycle wins, using the same priority.
    - On ack: discard data; pc<=pend (or the same-cycle redirect target); go REQ.
  - HOLD: imem_req=0; if_valid=1 with the held instr/pc.
    - !stall: consume; go REQ next cycle.
    - redir: drop the held instr; if_valid=0 next cycle; pc<=target; go REQ. Redirect beats stall.
- if_valid is registered. While stall=1 in REQ with no ack, if_valid holds its previous value and data.
- Latency: request to if_valid = ack latency + 1 cycle.

Optional Feature:
- FETCH_CNT_EN: adds an output port fetch_count (32 bits). It counts instructions delivered, i.e. if_valid=1 & !stall cycles. Resets to 0 and wraps at 2^32.
- Without the macro, the port and the counter are absent.

Decomposition:
- Package fetch_pkg:
  - state enum {BOOT, REQ, KILL, HOLD}
  - PC_STEP=4
  - default RESET_VECTOR and EXC_VECTOR
  - redirect source priority encoding
- One sub-module is natural: fetch_redirect_sel. It is combinational and produces redir and the aligned target from the three sources.

Test Plan:
- Reset, then imem_ack=1 every cycle → imem_addr 0,4,8,C; if_valid from cycle 3 with if_pc 0,4,8.
- Hold stall=1 for 3 cycles after fetch at 0x8 → if_instr stays at the word from 0x8, imem_req=0 in HOLD. Release stall → next fetch at 0xC.
- br_taken=1, br_target=0x103, while imem_ack=0 for 2 cycles → imem_addr stays old; returned data discarded; next imem_addr=0x100.
- exc_req, jmp_req and br_taken all asserted together → next fetch at 0x80.
- pc=0xFFFF_FFFC fetched → next imem_addr=0x0.
- Assert reset mid-KILL → imem_req=0 immediately; after release, fetch at RESET_VECTOR.
